// File: rtl/cy_skidbuffer_top.sv
// cy_skidbuffer_top: two cascaded skid buffers (master facing upstream, slave
// facing downstream) forming an elastic valid/ready slice that registers the
// ready path in both directions.
//
// Parameters:
//   DW          data word width
//   OPT_OUTREG  1: each stage drives valid/data from an output register
//               0: each stage drives valid/data from the skid mux
//
// Ports:
//   i_clk              clock, rising edge
//   i_reset            asynchronous active-high reset
//   up_bus/up_val      upstream word and valid
//   up_rdy             ready to upstream (skid flag of master, low in reset)
//   dn_rdy_next_stage  ready from downstream consumer
//   dn_val_slave       valid to downstream
//   dn_bus_slave       data to downstream
//   skid_occ           [1]=master skid full, [0]=slave skid full
//                      (present only when CY_SKID_STATUS_EN is defined)
//
// Build option: define CY_SKID_STATUS_EN to expose skid_occ.

// One skid stage: skid register plus optional output register.
module cy_skid_stage #(
    parameter int unsigned DW         = 8,
    parameter bit          OPT_OUTREG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          i_ready
);

    logic          s_valid;
    logic [DW-1:0] s_data;

    assign o_ready = !s_valid;

    // Park the incoming word when it is accepted while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else if (i_valid && !s_valid && o_valid && !i_ready) begin
            s_valid <= 1'b1;
            s_data  <= i_data;
        end else if (i_ready) begin
            s_valid <= 1'b0;
        end
    end

    generate
        if (OPT_OUTREG) begin : g_outreg
            logic          r_valid;
            logic [DW-1:0] r_data;

            // Output register loads whenever it is empty or being consumed.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (!r_valid || i_ready) begin
                    r_valid <= i_valid || s_valid;
                    r_data  <= s_valid ? s_data : i_data;
                end
            end

            assign o_valid = r_valid;
            assign o_data  = r_data;
        end else begin : g_comb
            assign o_valid = i_valid || s_valid;
            assign o_data  = s_valid ? s_data : i_data;
        end
    endgenerate

endmodule

module cy_skidbuffer_top #(
    parameter int unsigned DW         = 8,
    parameter bit          OPT_OUTREG = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [DW-1:0] up_bus,
    input  logic          up_val,
    output logic          up_rdy,
    input  logic          dn_rdy_next_stage,
    output logic          dn_val_slave,
    output logic [DW-1:0] dn_bus_slave
`ifdef CY_SKID_STATUS_EN
    ,
    output logic [1:0]    skid_occ
`endif
);

    logic          m_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          s_ready;

    cy_skid_stage #(
        .DW         (DW),
        .OPT_OUTREG (OPT_OUTREG)
    ) u_master (
        .clk     (i_clk),
        .rst     (i_reset),
        .i_valid (up_val),
        .i_data  (up_bus),
        .o_ready (m_ready),
        .o_valid (m_valid),
        .o_data  (m_data),
        .i_ready (s_ready)
    );

    cy_skid_stage #(
        .DW         (DW),
        .OPT_OUTREG (OPT_OUTREG)
    ) u_slave (
        .clk     (i_clk),
        .rst     (i_reset),
        .i_valid (m_valid),
        .i_data  (m_data),
        .o_ready (s_ready),
        .o_valid (dn_val_slave),
        .o_data  (dn_bus_slave),
        .i_ready (dn_rdy_next_stage)
    );

    // Ready is the inverted master skid flag; forced low while in reset.
    assign up_rdy = m_ready && !i_reset;

`ifdef CY_SKID_STATUS_EN
    // Stage ready is the inverse of each skid flag register.
    assign skid_occ = {!m_ready, !s_ready};
`endif

endmodule

// File: tb/tb_cy_skidbuffer_top.sv
// Directed bench for cy_skidbuffer_top: vector table for reset release,
// streaming, stall fill and drain; hand sequences for alternating ready and
// asynchronous reset while full.
module tb_cy_skidbuffer_top;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] up_bus;
    logic          up_val;
    logic          up_rdy;
    logic          dn_rdy;
    logic          dn_val;
    logic [DW-1:0] dn_bus;
`ifdef CY_SKID_STATUS_EN
    logic [1:0]    skid_occ;
`endif

    int n_checks = 0;
    int n_err    = 0;

    cy_skidbuffer_top #(
        .DW         (DW),
        .OPT_OUTREG (1'b1)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .up_bus            (up_bus),
        .up_val            (up_val),
        .up_rdy            (up_rdy),
        .dn_rdy_next_stage (dn_rdy),
        .dn_val_slave      (dn_val),
        .dn_bus_slave      (dn_bus)
`ifdef CY_SKID_STATUS_EN
        ,
        .skid_occ          (skid_occ)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          up_val;
        logic [DW-1:0] up_bus;
        logic          dn_rdy;
        logic          e_rdy;
        logic          e_val;
        logic          chk_bus;
        logic [DW-1:0] e_bus;
    } vec_t;

    vec_t vecs[13];

    logic [DW-1:0] q[$];
    logic [DW-1:0] fill_w[4];
    logic [DW-1:0] xd;
    logic          acc;
    logic          xfer;
    int            sent;

    initial begin
        // Inputs applied, one rising edge, then outputs compared.
        // Streaming: word visible downstream after the second edge.
        vecs[0]  = '{1'b1, 8'hB3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 8'hE3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hB3};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hE3};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        // Stall fill: four words accepted, fifth refused, head held.
        vecs[4]  = '{1'b1, 8'hF9, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hF9};
        vecs[6]  = '{1'b1, 8'h85, 1'b0, 1'b1, 1'b1, 1'b1, 8'hF9};
        vecs[7]  = '{1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF9};
        vecs[8]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF9};
        // Drain: F9 leaves on the raise edge; up_rdy back two edges later.
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h85};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hEF};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

        rst    = 1'b1;
        up_val = 1'b0;
        up_bus = '0;
        dn_rdy = 1'b0;

        // Reset held for 8 cycles.
        repeat (8) @(posedge clk);
        #1;
        chk("reset_dn_val", 32'(dn_val), 32'd0);
        chk("reset_dn_bus", 32'(dn_bus), 32'h00);
        chk("reset_up_rdy", 32'(up_rdy), 32'd0);
`ifdef CY_SKID_STATUS_EN
        chk("reset_skid_occ", 32'(skid_occ), 32'd0);
`endif
        rst = 1'b0;
        step();
        chk("release_up_rdy", 32'(up_rdy), 32'd1);
        chk("release_dn_val", 32'(dn_val), 32'd0);

        for (int i = 0; i < 13; i++) begin
            up_val = vecs[i].up_val;
            up_bus = vecs[i].up_bus;
            dn_rdy = vecs[i].dn_rdy;
            step();
            chk($sformatf("vec%0d_up_rdy", i), 32'(up_rdy), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_dn_val", i), 32'(dn_val), 32'(vecs[i].e_val));
            if (vecs[i].chk_bus)
                chk($sformatf("vec%0d_dn_bus", i), 32'(dn_bus), 32'(vecs[i].e_bus));
        end

        // Alternating downstream ready with a continuous incrementing stream.
        sent = 0;
        for (int cyc = 0; cyc < 80 && (sent < 24 || q.size() > 0); cyc++) begin
            dn_rdy = cyc[0];
            up_val = (sent < 24);
            up_bus = 8'(sent + 32'h40);
            acc    = up_val && up_rdy;
            xfer   = dn_val && dn_rdy;
            xd     = dn_bus;
            // Two or more words in flight means the slave must be presenting one.
            if (dn_rdy && q.size() >= 2)
                chk($sformatf("alt_no_gap_c%0d", cyc), 32'(dn_val), 32'd1);
            step();
            if (acc) begin
                q.push_back(up_bus);
                sent++;
            end
            if (xfer) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL alt_extra_word: got %0h expected no word", xd);
                end else begin
                    chk($sformatf("alt_order_c%0d", cyc), 32'(xd), 32'(q.pop_front()));
                end
            end
        end
        chk("alt_all_sent", 32'(sent), 32'd24);
        chk("alt_drained", 32'(q.size()), 32'd0);

        // Fill to capacity, then reset asynchronously between edges.
        fill_w[0] = 8'hA1;
        fill_w[1] = 8'hA2;
        fill_w[2] = 8'hA3;
        fill_w[3] = 8'hA4;
        dn_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            up_val = 1'b1;
            up_bus = fill_w[k];
            step();
        end
        up_val = 1'b0;
        chk("full_up_rdy", 32'(up_rdy), 32'd0);
        chk("full_dn_val", 32'(dn_val), 32'd1);
        chk("full_dn_bus", 32'(dn_bus), 32'hA1);
`ifdef CY_SKID_STATUS_EN
        chk("full_skid_occ", 32'(skid_occ), 32'd3);
`endif
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_dn_val", 32'(dn_val), 32'd0);
        chk("async_rst_dn_bus", 32'(dn_bus), 32'h00);
        chk("async_rst_up_rdy", 32'(up_rdy), 32'd0);
`ifdef CY_SKID_STATUS_EN
        chk("async_rst_skid_occ", 32'(skid_occ), 32'd0);
`endif
        step();
        step();
        rst    = 1'b0;
        dn_rdy = 1'b1;
        step();
        chk("post_rst_up_rdy", 32'(up_rdy), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("post_rst_no_word%0d", k), 32'(dn_val), 32'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
